// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset CPU sharing one memory bus for instruction fetch and data.
// Each instruction walks Fetch -> Decode -> Exec [-> Mem] [-> Wb]; memory states wait for ack.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   mem_req_o/mem_we_o     bus request (held until ack) and write strobe (sw only)
//   mem_addr_o/mem_wdata_o byte address and store data of the current transaction
//   mem_rdata_i/mem_ack_i  read data and completion, both sampled only while requesting
//   pc_out_o               PC of the instruction in flight
//   retire_o               one-cycle pulse in the last state of each instruction
//   halted_o               high while stopped in Halt (exit only by reset)
module mc_cpu #(
  parameter logic [31:0] RESET_PC        = 32'h0000_3000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] pc_out_o,
  output logic        retire_o,
  output logic        halted_o
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnJr    = 6'h08;
  localparam logic [5:0] FnAddu  = 6'h21;
  localparam logic [5:0] FnSubu  = 6'h23;

  state_e      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, res_q;
  logic [31:0] rf_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [31:0] imm_sext, imm_zext, pc_plus4, br_target, j_target, eff_addr;
  logic [31:0] rs_val, rt_val, alu_res, exec_pc;
  logic        is_addu, is_subu, is_sll, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic        is_beq, is_j, is_jal, legal, exec_retire;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_zext = {16'h0000, ir_q[15:0]};
  assign pc_plus4 = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign eff_addr  = a_q + imm_sext;

  assign is_addu = (op == OpRtype) && (funct == FnAddu);
  assign is_subu = (op == OpRtype) && (funct == FnSubu);
  assign is_sll  = (op == OpRtype) && (funct == FnSll);
  assign is_jr   = (op == OpRtype) && (funct == FnJr);
  assign is_ori  = (op == OpOri);
  assign is_lui  = (op == OpLui);
  assign is_lw   = (op == OpLw);
  assign is_sw   = (op == OpSw);
  assign is_beq  = (op == OpBeq);
  assign is_j    = (op == OpJ);
  assign is_jal  = (op == OpJal);
  assign legal   = is_addu | is_subu | is_sll | is_jr | is_ori | is_lui | is_lw | is_sw |
                   is_beq | is_j | is_jal;
  // Unsupported encodings only reach Exec when not halting on them; they retire there as nops.
  assign exec_retire = is_beq | is_j | is_jr | ~legal;

  assign dest   = (op == OpRtype) ? rd : (is_jal ? 5'd31 : rt);
  assign rs_val = (rs == 5'd0) ? 32'h0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : rf_q[rt];

  always_comb begin
    alu_res = pc_plus4;  // jal link value
    if (is_addu)     alu_res = a_q + b_q;
    else if (is_subu) alu_res = a_q - b_q;
    else if (is_sll)  alu_res = b_q << shamt;
    else if (is_ori)  alu_res = a_q | imm_zext;
    else if (is_lui)  alu_res = {ir_q[15:0], 16'h0000};
  end

  always_comb begin
    exec_pc = pc_plus4;
    if (is_jr)                       exec_pc = a_q;
    else if (is_j)                   exec_pc = j_target;
    else if (is_beq && (a_q == b_q)) exec_pc = br_target;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (mem_ack_i) begin
            ir_q    <= mem_rdata_i;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          a_q     <= rs_val;
          b_q     <= rt_val;
          state_q <= (!legal && HALT_ON_ILLEGAL) ? StHalt : StExec;
        end
        StExec: begin
          if (is_lw || is_sw) begin
            // Misaligned accesses stop the core before any bus request is issued.
            if (eff_addr[1:0] != 2'b00) begin
              state_q <= StHalt;
            end else begin
              res_q   <= eff_addr;
              state_q <= StMem;
            end
          end else if (exec_retire) begin
            pc_q    <= exec_pc;
            state_q <= StFetch;
          end else begin
            res_q   <= alu_res;
            state_q <= StWb;
          end
        end
        StMem: begin
          if (mem_ack_i) begin
            if (is_sw) begin
              pc_q    <= pc_plus4;
              state_q <= StFetch;
            end else begin
              res_q   <= mem_rdata_i;
              state_q <= StWb;
            end
          end
        end
        StWb: begin
          if (dest != 5'd0) rf_q[dest] <= res_q;
          pc_q    <= is_jal ? j_target : pc_plus4;
          state_q <= StFetch;
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StHalt;
      endcase
    end
  end

  // Gating with rst_ni drops the request the moment reset asserts, even mid-transaction.
  assign mem_req_o   = rst_ni & ((state_q == StFetch) | (state_q == StMem));
  assign mem_we_o    = rst_ni & (state_q == StMem) & is_sw;
  assign mem_addr_o  = (state_q == StMem) ? res_q : pc_q;
  assign mem_wdata_o = b_q;
  assign pc_out_o    = pc_q;
  assign retire_o    = (state_q == StWb) | ((state_q == StExec) & exec_retire) |
                       ((state_q == StMem) & is_sw & mem_ack_i);
  assign halted_o    = (state_q == StHalt);

endmodule

// File: tb/tb_mc_cpu.sv
// Self-checking bench for mc_cpu: a bus responder with programmable ack latency, a retire
// monitor, and an instruction-level reference model that executes the same program.
module tb_mc_cpu;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] ILL    = 32'hFC00_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        mem_req_o, mem_we_o, retire_o, halted_o;
  logic [31:0] mem_addr_o, mem_wdata_o, pc_out_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;

  mc_cpu #(.RESET_PC(RST_PC), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .pc_out_o(pc_out_o), .retire_o(retire_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_fail = 0;
  logic [31:0] mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] prog [$];

  function automatic logic [31:0] tb_rd(input logic [31:0] a);
    int unsigned k = int'(a >> 2);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int unsigned k = int'(a >> 2);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  // ---------------- bus responder ----------------
  int min_dly = 0, max_dly = 0;
  bit stray = 1'b0;
  int cnt, dly, stab_err, req_cnt;
  bit active;
  logic [31:0] t_addr, t_wdata;
  logic t_we;
  logic [31:0] wr_addr_q [$], wr_data_q [$];

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      mem_ack_i = 1'b0; active = 1'b0; cnt = 0; stab_err = 0; req_cnt = 0;
      wr_addr_q.delete(); wr_data_q.delete();
    end else if (mem_req_o) begin
      if (!active) begin
        active = 1'b1; cnt = 0; dly = $urandom_range(max_dly, min_dly);
        t_addr = mem_addr_o; t_we = mem_we_o; t_wdata = mem_wdata_o; req_cnt++;
      end else if (mem_addr_o !== t_addr || mem_we_o !== t_we ||
                   (t_we && mem_wdata_o !== t_wdata)) begin
        stab_err++;
      end
      if (cnt >= dly) begin
        mem_ack_i = 1'b1; active = 1'b0;
        if (t_we) begin
          mem[int'(t_addr >> 2)] = t_wdata;
          wr_addr_q.push_back(t_addr); wr_data_q.push_back(t_wdata);
          mem_rdata_i = $urandom;
        end else begin
          mem_rdata_i = tb_rd(t_addr);
        end
      end else begin
        mem_ack_i = 1'b0; mem_rdata_i = $urandom; cnt++;
      end
    end else begin
      if (active) stab_err++;  // request withdrawn before ack
      active = 1'b0; mem_ack_i = stray; mem_rdata_i = $urandom;
    end
  end

  // ---------------- retire monitor ----------------
  int cyc, halt_cyc, first_req_cyc;
  logic [31:0] first_req_addr;
  logic [31:0] ret_pc_q [$];
  int ret_cyc_q [$];

  always @(negedge clk_i) begin
    #1;
    if (!rst_ni) begin
      cyc = 0; halt_cyc = 0; first_req_cyc = 0; first_req_addr = '0;
      ret_pc_q.delete(); ret_cyc_q.delete();
    end else begin
      cyc++;
      if (retire_o) begin ret_pc_q.push_back(pc_out_o); ret_cyc_q.push_back(cyc); end
      if (halted_o && halt_cyc == 0) halt_cyc = cyc;
      if (mem_req_o && first_req_cyc == 0) begin first_req_cyc = cyc; first_req_addr = mem_addr_o; end
    end
  end

  // ---------------- instruction-level reference model ----------------
  logic [31:0] exp_pc_q [$];
  int exp_cyc_q [$];
  bit exp_halt;
  int exp_halt_cyc;

  task automatic iss_run(input int max_steps);
    logic [31:0] r [32];
    logic [31:0] pc, ir, pc4, npc, val, ea, se;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rdd, sh, dst;
    int cost, c;
    bit wr, stop;
    for (int i = 0; i < 32; i++) r[i] = '0;
    pc = RST_PC; c = 0; exp_halt = 0; exp_halt_cyc = 0;
    exp_pc_q.delete(); exp_cyc_q.delete();
    for (int s = 0; s < max_steps; s++) begin
      ir = ref_rd(pc); op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rdd = ir[15:11];
      sh = ir[10:6]; fn = ir[5:0]; se = {{16{ir[15]}}, ir[15:0]};
      pc4 = pc + 32'd4; npc = pc4; wr = 0; dst = rt; val = '0; stop = 0; cost = 4;
      case (op)
        6'h00: begin
          dst = rdd; wr = 1;
          case (fn)
            6'h21: val = r[rs] + r[rt];
            6'h23: val = r[rs] - r[rt];
            6'h00: val = r[rt] << sh;
            6'h08: begin wr = 0; npc = r[rs]; cost = 3; end
            default: begin stop = 1; cost = 2; end
          endcase
        end
        6'h0D: begin wr = 1; val = r[rs] | {16'h0, ir[15:0]}; end
        6'h0F: begin wr = 1; val = {ir[15:0], 16'h0}; end
        6'h23: begin
          ea = r[rs] + se;
          if (ea[1:0] != 2'b00) begin stop = 1; cost = 3; end
          else begin wr = 1; val = ref_rd(ea); cost = 5; end
        end
        6'h2B: begin
          ea = r[rs] + se;
          if (ea[1:0] != 2'b00) begin stop = 1; cost = 3; end
          else ref_mem[int'(ea >> 2)] = r[rt];
        end
        6'h04: begin cost = 3; if (r[rs] == r[rt]) npc = pc4 + (se << 2); end
        6'h02: begin cost = 3; npc = {pc4[31:28], ir[25:0], 2'b00}; end
        6'h03: begin wr = 1; dst = 5'd31; val = pc4; npc = {pc4[31:28], ir[25:0], 2'b00}; end
        default: begin stop = 1; cost = 2; end
      endcase
      if (stop) begin exp_halt = 1; exp_halt_cyc = c + cost + 1; break; end
      c += cost;
      exp_pc_q.push_back(pc); exp_cyc_q.push_back(c);
      if (wr && dst != 5'd0) r[dst] = val;
      pc = npc;
    end
  endtask

  task automatic load_prog();
    mem.delete(); ref_mem.delete();
    foreach (prog[i]) begin
      mem[int'(RST_PC >> 2) + i] = prog[i];
      ref_mem[int'(RST_PC >> 2) + i] = prog[i];
    end
  endtask

  task automatic run_dut(input int budget);
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (halted_o) break;
      @(negedge clk_i);
    end
    repeat (8) @(negedge clk_i);
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    #3;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
    n_cmp++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", mem_we_o); end
    n_cmp++; if (retire_o !== 1'b0) begin n_fail++; $display("FAIL rst_retire: got %b want 0", retire_o); end
    n_cmp++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted_o); end
    n_cmp++; if (pc_out_o !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc_out_o, RST_PC); end
    prog = '{enc_i(6'h0D, 0, 1, 16'h1234), ILL};
    load_prog(); min_dly = 0; max_dly = 0;
    run_dut(50);
    n_cmp++; if (first_req_cyc !== 1) begin n_fail++; $display("FAIL first_req_cyc: got %0d want 1", first_req_cyc); end
    n_cmp++; if (first_req_addr !== RST_PC) begin n_fail++; $display("FAIL first_req_addr: got %h want %h", first_req_addr, RST_PC); end
  endtask

  task automatic test_basic();
    prog = '{enc_i(6'h0D, 0, 1, 16'h1234), enc_i(6'h0F, 0, 2, 16'hABCD),
             enc_r(1, 2, 3, 0, 6'h21), enc_i(6'h2B, 0, 3, 16'h0040), ILL};
    load_prog(); iss_run(100); min_dly = 0; max_dly = 0;
    run_dut(200);
    n_cmp++; if (ret_cyc_q.size() < 3 || ret_cyc_q[0] != 4 || ret_cyc_q[1] != 8 || ret_cyc_q[2] != 12) begin
      n_fail++; $display("FAIL basic_retire_cycles: got %p want 4,8,12,...", ret_cyc_q); end
    n_cmp++; if (tb_rd(32'h40) !== 32'hABCD_1234) begin n_fail++; $display("FAIL basic_r3: got %h want abcd1234", tb_rd(32'h40)); end
    n_cmp++; if (ret_cyc_q != exp_cyc_q) begin n_fail++; $display("FAIL basic_cycles: got %p want %p", ret_cyc_q, exp_cyc_q); end
    n_cmp++; if (halt_cyc != exp_halt_cyc) begin n_fail++; $display("FAIL basic_halt_cyc: got %0d want %0d", halt_cyc, exp_halt_cyc); end
  endtask

  task automatic test_mem_wait();
    prog = '{enc_i(6'h0D, 0, 1, 16'h1234), enc_i(6'h0F, 0, 2, 16'hABCD),
             enc_r(1, 2, 3, 0, 6'h21), enc_i(6'h2B, 0, 3, 16'h0000),
             enc_i(6'h23, 0, 4, 16'h0000), enc_i(6'h2B, 0, 4, 16'h0004), ILL};
    load_prog(); iss_run(100); min_dly = 3; max_dly = 3;
    run_dut(400);
    n_cmp++; if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL wait_nwrites: got %0d want 2", wr_addr_q.size()); end
    else begin
      n_cmp++; if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'hABCD_1234) begin
        n_fail++; $display("FAIL wait_sw: got %h/%h want 0/abcd1234", wr_addr_q[0], wr_data_q[0]); end
      n_cmp++; if (wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'hABCD_1234) begin
        n_fail++; $display("FAIL wait_lw_r4: got %h/%h want 4/abcd1234", wr_addr_q[1], wr_data_q[1]); end
    end
    n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL wait_stable: got %0d glitches want 0", stab_err); end
    n_cmp++; if (ret_pc_q != exp_pc_q) begin n_fail++; $display("FAIL wait_retire_pcs: got %p want %p", ret_pc_q, exp_pc_q); end
    n_cmp++; if (halted_o !== 1'b1) begin n_fail++; $display("FAIL wait_halted: got %b want 1", halted_o); end
    min_dly = 0; max_dly = 0;
  endtask

  task automatic test_branch();
    int n;
    prog = '{enc_i(6'h0D, 0, 1, 16'h0007), enc_i(6'h04, 1, 0, 16'h0002),
             enc_i(6'h0D, 0, 2, 16'h0001), enc_i(6'h0D, 0, 3, 16'h0002),
             enc_j(6'h03, 26'h0000C08), ILL, ILL, ILL,
             enc_i(6'h2B, 0, 31, 16'h0020), enc_i(6'h0D, 0, 5, 16'h3030),
             enc_r(5, 0, 0, 0, 6'h08), ILL, enc_i(6'h04, 0, 0, 16'hFFFF)};
    load_prog(); iss_run(200); min_dly = 0; max_dly = 0;
    run_dut(150);
    n = ret_pc_q.size();
    n_cmp++; if (n < 12) begin n_fail++; $display("FAIL br_nretire: got %0d want >=12", n); end
    else begin
      n_cmp++; if (ret_pc_q[2] !== 32'h3008) begin n_fail++; $display("FAIL br_not_taken: got %h want 3008", ret_pc_q[2]); end
      n_cmp++; if (ret_pc_q[n-1] !== 32'h3030 || ret_pc_q[n-3] !== 32'h3030) begin
        n_fail++; $display("FAIL br_self_loop: got %h,%h want 3030", ret_pc_q[n-3], ret_pc_q[n-1]); end
    end
    n_cmp++; if (tb_rd(32'h20) !== 32'h3014) begin n_fail++; $display("FAIL jal_link: got %h want 3014", tb_rd(32'h20)); end
    n_cmp++; if (pc_out_o !== 32'h3030) begin n_fail++; $display("FAIL br_pc_out: got %h want 3030", pc_out_o); end
    n_cmp++; if (halted_o !== 1'b0) begin n_fail++; $display("FAIL br_halted: got %b want 0", halted_o); end
    for (int i = 0; i < n && i < exp_pc_q.size(); i++) begin
      n_cmp++;
      if (ret_pc_q[i] !== exp_pc_q[i] || ret_cyc_q[i] != exp_cyc_q[i]) begin
        n_fail++; $display("FAIL br_retire[%0d]: got %h@%0d want %h@%0d", i, ret_pc_q[i], ret_cyc_q[i], exp_pc_q[i], exp_cyc_q[i]); end
    end
  endtask

  task automatic test_halt();
    prog = '{enc_i(6'h0D, 0, 1, 16'h0002), enc_i(6'h23, 1, 2, 16'h0000),
             enc_i(6'h0D, 0, 3, 16'h0003), ILL};
    load_prog(); iss_run(100);
    run_dut(100);
    n_cmp++; if (halted_o !== 1'b1) begin n_fail++; $display("FAIL mis_halted: got %b want 1", halted_o); end
    n_cmp++; if (halt_cyc != 8) begin n_fail++; $display("FAIL mis_halt_cyc: got %0d want 8", halt_cyc); end
    n_cmp++; if (req_cnt != 2) begin n_fail++; $display("FAIL mis_reqs: got %0d want 2", req_cnt); end
    n_cmp++; if (ret_pc_q != exp_pc_q) begin n_fail++; $display("FAIL mis_retires: got %p want %p", ret_pc_q, exp_pc_q); end
    prog = '{enc_i(6'h0D, 0, 1, 16'h0001), 32'hFC00_0000, enc_i(6'h0D, 0, 3, 16'h0003)};
    load_prog(); iss_run(100);
    run_dut(100);
    n_cmp++; if (halted_o !== 1'b1) begin n_fail++; $display("FAIL ill_halted: got %b want 1", halted_o); end
    n_cmp++; if (halt_cyc != exp_halt_cyc || halt_cyc != 7) begin n_fail++; $display("FAIL ill_halt_cyc: got %0d want 7", halt_cyc); end
    n_cmp++; if (req_cnt != 2) begin n_fail++; $display("FAIL ill_reqs: got %0d want 2", req_cnt); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    prog = '{enc_i(6'h0D, 0, 1, 16'h0055), enc_i(6'h0D, 0, 2, 16'h0066),
             enc_i(6'h04, 0, 0, 16'hFFFF)};
    load_prog(); min_dly = 4; max_dly = 4;
    rst_ni = 1'b0; repeat (2) @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (40) @(negedge clk_i);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_i); #2;
      if (mem_req_o && active && cnt == 1) begin hit = 1; break; end
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL mid_wait: got no pending request want one"); end
    rst_ni = 1'b0; #1;
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL mid_req_drop: got %b want 0", mem_req_o); end
    prog = '{enc_i(6'h2B, 0, 1, 16'h0080), enc_i(6'h2B, 0, 2, 16'h0084), ILL};
    load_prog(); min_dly = 0; max_dly = 0;
    run_dut(100);
    n_cmp++; if (first_req_addr !== RST_PC || first_req_cyc != 1) begin
      n_fail++; $display("FAIL mid_first_fetch: got %h@%0d want %h@1", first_req_addr, first_req_cyc, RST_PC); end
    n_cmp++; if (tb_rd(32'h80) !== 32'h0 || tb_rd(32'h84) !== 32'h0) begin
      n_fail++; $display("FAIL mid_gpr_clear: got %h,%h want 0,0", tb_rd(32'h80), tb_rd(32'h84)); end
  endtask

  task automatic test_zero_stray();
    prog = '{enc_i(6'h0D, 0, 1, 16'h0005), enc_r(1, 1, 0, 0, 6'h21),
             enc_i(6'h2B, 0, 0, 16'h0060), enc_r(0, 1, 2, 0, 6'h21),
             enc_i(6'h2B, 0, 2, 16'h0064), ILL};
    load_prog(); iss_run(100); stray = 1'b1;
    run_dut(200);
    stray = 1'b0;
    n_cmp++; if (tb_rd(32'h60) !== 32'h0) begin n_fail++; $display("FAIL zero_reg: got %h want 0", tb_rd(32'h60)); end
    n_cmp++; if (tb_rd(32'h64) !== 32'h5) begin n_fail++; $display("FAIL zero_src: got %h want 5", tb_rd(32'h64)); end
    n_cmp++; if (ret_cyc_q != exp_cyc_q) begin n_fail++; $display("FAIL stray_timing: got %p want %p", ret_cyc_q, exp_cyc_q); end
  endtask

  task automatic test_random();
    logic [4:0] a, b, c;
    for (int it = 0; it < 6; it++) begin
      prog.delete();
      for (int k = 0; k < 20; k++) begin
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
          0: prog.push_back(enc_r(a, b, c, 0, 6'h21));
          1: prog.push_back(enc_r(a, b, c, 0, 6'h23));
          2: prog.push_back(enc_r(0, b, c, 5'($urandom_range(0, 31)), 6'h00));
          3: prog.push_back(enc_i(6'h0D, a, b, 16'($urandom)));
          4: prog.push_back(enc_i(6'h0F, 0, b, 16'($urandom)));
          5: prog.push_back(enc_i(6'h2B, 0, b, 16'(32'h100 + 4 * $urandom_range(0, 15))));
          6: prog.push_back(enc_i(6'h23, 0, b, 16'(32'h100 + 4 * $urandom_range(0, 15))));
          default: prog.push_back(enc_i(6'h04, a, b, 16'h0001));
        endcase
      end
      for (int k = 1; k < 8; k++) prog.push_back(enc_i(6'h2B, 0, 5'(k), 16'(32'h200 + 4 * k)));
      prog.push_back(ILL);
      load_prog(); iss_run(500);
      min_dly = 0; max_dly = (it < 2) ? 0 : 3;
      run_dut(3000);
      for (int w = 0; w < 16; w++) begin
        n_cmp++; if (tb_rd(32'h100 + 4 * w) !== ref_rd(32'h100 + 4 * w)) begin
          n_fail++; $display("FAIL rnd%0d_mem[%h]: got %h want %h", it, 32'h100 + 4 * w, tb_rd(32'h100 + 4 * w), ref_rd(32'h100 + 4 * w)); end
      end
      for (int k = 1; k < 8; k++) begin
        n_cmp++; if (tb_rd(32'h200 + 4 * k) !== ref_rd(32'h200 + 4 * k)) begin
          n_fail++; $display("FAIL rnd%0d_r%0d: got %h want %h", it, k, tb_rd(32'h200 + 4 * k), ref_rd(32'h200 + 4 * k)); end
      end
      n_cmp++; if (ret_pc_q != exp_pc_q) begin n_fail++; $display("FAIL rnd%0d_retire_pcs: got %0d retires want %0d", it, ret_pc_q.size(), exp_pc_q.size()); end
      n_cmp++; if (halted_o !== exp_halt) begin n_fail++; $display("FAIL rnd%0d_halted: got %b want %b", it, halted_o, exp_halt); end
      n_cmp++; if (stab_err != 0) begin n_fail++; $display("FAIL rnd%0d_stable: got %0d want 0", it, stab_err); end
      if (max_dly == 0) begin
        n_cmp++; if (ret_cyc_q != exp_cyc_q) begin n_fail++; $display("FAIL rnd%0d_cycles: got %p want %p", it, ret_cyc_q, exp_cyc_q); end
      end
    end
    min_dly = 0; max_dly = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_mem_wait();
    test_branch();
    test_halt();
    test_reset_mid();
    test_zero_stray();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mc_cpu.md
MC_CPU -- requirements
Module: mc_cpu

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: address of the first instruction fetched after reset.
REQ-002 Parameter HALT_ON_ILLEGAL, default 1: 1 = enter HALT on an unsupported opcode or funct; 0 = treat it as nop.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 mem_req  output  1  shared memory bus request, held until acknowledged.
REQ-006 mem_we  output  1  1 = write (sw), 0 = read (fetch, lw).
REQ-007 mem_addr  output  32  byte address of the current transaction.
REQ-008 mem_wdata  output  32  store data, valid while mem_req & mem_we.
REQ-009 mem_rdata  input  32  read data, valid in the cycle mem_ack=1.
REQ-010 mem_ack  input  1  transaction complete; sampled only while mem_req=1.
REQ-011 pc_out  output  32  PC of the instruction currently executing.
REQ-012 retire  output  1  one-cycle pulse in the final state of each completed instruction.
REQ-013 halted  output  1  1 while in HALT.

Function
REQ-014 The FSM SHALL use states FETCH, DECODE, EXEC, MEM, WB and HALT, one state per cycle except for memory waits.
REQ-015 FETCH SHALL assert mem_req=1, mem_we=0, mem_addr=PC, and hold them until mem_ack=1; on ack, latch IR=mem_rdata and go to DECODE.
REQ-016 An ack arriving in the same cycle as the request SHALL complete the transaction (zero wait); each additional cycle with ack=0 adds one cycle of latency.
REQ-017 mem_ack while mem_req=0 SHALL be ignored.
REQ-018 mem_addr, mem_we and mem_wdata SHALL stay stable from request until ack.
REQ-019 DECODE SHALL read rs/rt into A/B latches; register $0 SHALL read as 0 and ignore writes.
REQ-020 Supported instructions: addu, subu, sll, jr (R-type); ori, lui, lw, sw, beq, j, jal.
REQ-021 Arithmetic SHALL be 32-bit modulo with overflow ignored.
REQ-022 ori SHALL zero-extend the immediate; lw, sw and beq SHALL sign-extend it; lui SHALL produce imm<<16.
REQ-023 There SHALL be no branch delay slot.
REQ-024 beq taken: next PC = PC+4+(sext(imm)<<2); not taken: PC+4.
REQ-025 j/jal SHALL target {PC+4[31:28], idx, 2'b00}; jal SHALL write PC+4 to $31; jr SHALL target rs.
REQ-026 Cycle counts with zero-wait memory SHALL be: beq/j/jr = 3 (FETCH, DECODE, EXEC); addu/subu/sll/ori/lui/jal = 4 (+WB); sw = 4 (+MEM); lw = 5 (+MEM, WB).
REQ-027 MEM SHALL present the address from EXEC; lw SHALL latch mem_rdata on ack and proceed to WB; sw SHALL retire on ack.
REQ-028 retire SHALL pulse in the last state of each instruction, and the PC SHALL update on that same edge.
REQ-029 The next state after retire SHALL be FETCH.
REQ-030 A lw/sw with address[1:0]!=0 SHALL go from EXEC to HALT without issuing a bus request.
REQ-031 An illegal instruction with HALT_ON_ILLEGAL=1 SHALL go from DECODE to HALT.
REQ-032 HALT SHALL be absorbing: mem_req=0, retire=0, halted=1; only reset exits it.
REQ-033 PC+4 SHALL wrap modulo 2^32.

Reset
REQ-034 While reset=0: state=FETCH, PC=RESET_PC, all GPRs=0, mem_req=0, mem_we=0, retire=0, halted=0, pc_out=RESET_PC.
REQ-035 Reset asserted mid-transaction SHALL drop mem_req combinationally and abandon the transaction.
REQ-036 The first request after reset release SHALL occur in the cycle following the release.

Verification
REQ-037 ori $1,$0,0x1234; lui $2,0xABCD; addu $3,$1,$2 with zero-wait memory -> $3=0xABCD1234, retire pulses at cycles 4, 8 and 12.
REQ-038 sw $3,0($0) then lw $4,0($0), with mem_ack delayed 3 cycles per transaction -> write seen with addr 0 and data 0xABCD1234, $4=0xABCD1234, mem_req held steady throughout.
REQ-039 beq $0,$0,-1 -> pc_out stays at the same address; beq $1,$0,+2 with $1!=0 -> PC+4; jal at 0x3010 -> $31=0x3014.
REQ-040 lw with address 0x2 -> halted=1 after EXEC, no further mem_req; opcode 0x3F -> halted=1 after DECODE.
REQ-041 Reset pulsed while mem_req=1 and ack pending -> mem_req=0 immediately; after release the first fetch is at 0x3000 and all GPRs=0.
REQ-042 addu $0,$1,$1 -> $0 still reads 0; mem_ack pulsed in DECODE -> no effect.
